framebuffer_arbiter: RTL and testbench
======================================

// Module: framebuffer_arbiter
// PURPOSE
//  Shares one single-port frame-buffer memory port (PSRAM controller side) between two requesters:
//  VGA scanline prefetch bursts (priority) and MCU pixel writes.
//  Sits between mcu_bus/vga and the PSRAM controller in the msgpu top level.
//  MCU writes are buffered in a small FIFO and drained only while no fetch burst is active.
// PARAMETERS
//  ADDR_WIDTH   21  memory word address width
//  DATA_WIDTH   16  memory word width
//  BURST_LEN    8   words per scanline fetch burst (>=1)
//  WFIFO_DEPTH  4   write FIFO entries (power of 2, >=2)
// PORTS
//  clock          in   1           system clock
//  reset          in   1           asynchronous, active-high reset
//  wr_valid       in   1           MCU write request
//  wr_ready       out  1           FIFO not full; push when wr_valid&&wr_ready
//  wr_addr        in   ADDR_WIDTH  write address
//  wr_data        in   DATA_WIDTH  write data
//  fetch_req      in   1           1-cycle pulse: start burst at fetch_addr
//  fetch_addr     in   ADDR_WIDTH  burst start address
//  fetch_busy     out  1           burst pending or in progress
//  rd_valid       out  1           rd_data holds one burst word
//  rd_data        out  DATA_WIDTH  burst read data, in address order
//  fetch_overrun  out  1           sticky: fetch_req arrived while fetch_busy
//  overrun_clear  in   1           clears fetch_overrun
//  mem_req        out  1           access request; held with fields stable until mem_ack
//  mem_we         out  1           1=write, 0=read
//  mem_addr       out  ADDR_WIDTH  access address
//  mem_wdata      out  DATA_WIDTH  write data
//  mem_ack        in   1           1-cycle completion pulse; mem_rdata valid this cycle on reads
//  mem_rdata      in   DATA_WIDTH  read data
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty (wr_ready=1 after reset release), no pending fetch.
//  FSM states: IDLE, READ, WRITE.
//   IDLE:  fetch pending -> READ (mem_req=1, mem_we=0, mem_addr=start, beat count=0).
//          Otherwise FIFO non-empty -> WRITE (head entry on mem_*).
//          Otherwise stay in IDLE.
//   READ:  on mem_ack, capture rdata; rd_valid=1 the next cycle (1-cycle latency), beat count+1.
//          Beat < BURST_LEN-1: mem_req stays 1, mem_addr+1 in the cycle after ack.
//          Last beat: fetch_busy clears and the state goes to IDLE.
//   WRITE: on mem_ack, pop FIFO.
//          Fetch pending -> READ with no idle gap; else FIFO still non-empty -> next WRITE
//          back-to-back; else IDLE.
//  The request in flight is never abandoned. A fetch_req arriving during WRITE waits for that ack.
//  Worst-case fetch start latency: one write access + 1 cycle.
//  mem_req never drops before mem_ack. Fields may change only in the cycle after ack.
//  fetch_req is accepted when !fetch_busy. fetch_busy=1 from the next cycle until the cycle after the last ack.
//  fetch_req while fetch_busy: ignored, fetch_overrun<=1.
//   overrun_clear wins over a simultaneous set.
//  Address arithmetic is modulo 2^ADDR_WIDTH: a burst wraps from all-ones to 0.
//  FIFO: push and pop in the same cycle are both legal. Count is unchanged and wr_ready stays as before.
//   Full: wr_ready=0 and wr_valid is ignored.
//  Reset mid-access: mem_req drops immediately (async). The PSRAM controller tolerates an abandoned request.
//   FIFO contents and any partial burst are discarded.
// STRUCTURE
//  Package fb_arbiter_pkg: FSM state enum (ST_IDLE, ST_READ, ST_WRITE); default widths;
//  burst counter width $clog2(BURST_LEN+1).
//  Sub-module fb_write_fifo: synchronous FIFO, {addr,data} entries.
//   Ports: push/pop/full/empty/head. Same clock and reset.
//  The arbiter holds the FSM, beat counter, address register, rd_data register and overrun flag.
// TESTING (bench memory model: ack 2 cycles after req, rdata = addr[15:0] ^ 16'hA5A5)
//  1. Reset mid-burst (during beat 3) -> mem_req=0, rd_valid=0, wr_ready=1 while reset is high.
//     Fresh fetch after release -> clean 8 beats.
//  2. fetch_req, addr 0x00100, idle FIFO -> 8 mem_req reads at 0x00100..0x00107; 8 rd_valid words in order.
//     fetch_busy drops after the 8th word.
//  3. 5 back-to-back MCU writes, no fetch -> wr_ready low on the 5th attempt until the first ack.
//     All 5 appear on mem_* in push order.
//  4. fetch_req one cycle after a write starts -> write completes first; READ follows with no gap.
//     Remaining FIFO writes resume only after the burst.
//  5. fetch_addr 0x1FFFFE -> burst addresses 0x1FFFFE, 0x1FFFFF, 0x000000..0x000005.
//  6. Second fetch_req mid-burst -> ignored, fetch_overrun=1.
//     overrun_clear and a new overrun in the same cycle -> flag=0.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// fb_arbiter_pkg: shared types and default sizes for the frame-buffer arbiter.
// Holds the arbiter FSM state enum and the burst beat-counter width helper.
package fb_arbiter_pkg;

    localparam int FB_ADDR_WIDTH  = 21;
    localparam int FB_DATA_WIDTH  = 16;
    localparam int FB_BURST_LEN   = 8;
    localparam int FB_WFIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } fb_state_t;

    function automatic int beat_cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// fb_write_fifo: synchronous FIFO buffering MCU {addr,data} pixel writes.
// Ports: push/push_entry in, pop in, full/empty/count/head out; async active-high reset.
module fb_write_fifo
    import fb_arbiter_pkg::*;
#(
    parameter int WIDTH = FB_ADDR_WIDTH + FB_DATA_WIDTH,
    parameter int DEPTH = FB_WFIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign count = wptr - rptr;
    assign head  = mem[rptr[PW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[PW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one PSRAM port between VGA burst fetches and buffered MCU writes.
// Ports: wr_* MCU write side, fetch_*/rd_* VGA burst side, mem_* PSRAM controller side.
module framebuffer_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = FB_DATA_WIDTH,
    parameter int BURST_LEN   = FB_BURST_LEN,
    parameter int WFIFO_DEPTH = FB_WFIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fetch_overrun,
    input  logic                  overrun_clear,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BW = beat_cnt_width(BURST_LEN);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [PW:0]   ONE_ENTRY = (PW + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    fb_state_t state;
    fb_state_t state_nx;

    logic [BW-1:0]         beat;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [PW:0]           fifo_count;
    logic [EW-1:0]         fifo_head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fetch_accept;
    logic                  read_ack;
    logic                  last_ack;
    logic                  more_writes;

    assign wr_ready     = !fifo_full;
    assign fifo_push    = wr_valid && !fifo_full;
    assign fifo_pop     = (state == ST_WRITE) && mem_ack;
    assign {head_addr, head_data} = fifo_head;
    assign fetch_accept = fetch_req && !fetch_busy;
    assign read_ack     = (state == ST_READ) && mem_ack;
    assign last_ack     = read_ack && (beat == LAST_BEAT);
    // FIFO still holds an entry once the current head is popped.
    assign more_writes  = (fifo_count > ONE_ENTRY) || fifo_push;

    fb_write_fifo #(
        .WIDTH (EW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry ({wr_addr, wr_data}),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Outside READ, fetch_busy means a fetch is accepted but not yet started.
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            ST_IDLE: begin
                if (fetch_busy)       state_nx = ST_READ;
                else if (!fifo_empty) state_nx = ST_WRITE;
            end
            ST_READ: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr;
                if (last_ack) state_nx = ST_IDLE;
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
                if (mem_ack) begin
                    if (fetch_busy)       state_nx = ST_READ;
                    else if (more_writes) state_nx = ST_WRITE;
                    else                  state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Burst address wraps naturally at the register width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_busy <= 1'b0;
            rd_addr    <= '0;
            beat       <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (fetch_accept) begin
                fetch_busy <= 1'b1;
                rd_addr    <= fetch_addr;
                beat       <= '0;
            end
            if (read_ack) begin
                rd_data  <= mem_rdata;
                rd_valid <= 1'b1;
                rd_addr  <= rd_addr + ADDR_ONE;
                if (last_ack) begin
                    beat       <= '0;
                    fetch_busy <= 1'b0;
                end else begin
                    beat <= beat + BEAT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         fetch_overrun <= 1'b0;
        else if (overrun_clear)            fetch_overrun <= 1'b0;
        else if (fetch_req && fetch_busy)  fetch_overrun <= 1'b1;
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: scoreboard bench for framebuffer_arbiter with a PSRAM model.
// Model acks in the third cycle of each request; read data is addr[15:0] ^ 16'hA5A5.
module tb_framebuffer_arbiter;

    typedef struct {
        logic        we;
        logic [20:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [20:0] addr;
    } post_t;

    logic        clock;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [20:0] wr_addr;
    logic [15:0] wr_data;
    logic        fetch_req;
    logic [20:0] fetch_addr;
    logic        fetch_busy;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        fetch_overrun;
    logic        overrun_clear;
    logic        mem_req;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks;
    int failures;
    int mcnt;

    acc_t        exp_acc[$];
    acc_t        acc_log[$];
    logic [15:0] exp_rd[$];
    logic [15:0] rd_log[$];
    post_t       post_log[$];

    framebuffer_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_busy    (fetch_busy),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fetch_overrun (fetch_overrun),
        .overrun_clear (overrun_clear),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // PSRAM model and read-word monitor, both on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mcnt    = 0;
            post_log.push_back('{mem_req, mem_we, mem_addr});
        end else if (mem_req) begin
            mcnt++;
            if (mcnt == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr[15:0] ^ 16'hA5A5;
                acc_log.push_back('{mem_we, mem_addr, mem_wdata});
            end
        end
        if (!reset && rd_valid) rd_log.push_back(rd_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_logs();
        exp_acc.delete();
        acc_log.delete();
        exp_rd.delete();
        rd_log.delete();
        post_log.delete();
    endtask

    task automatic do_fetch(input logic [20:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
    endtask

    task automatic exp_burst(input logic [20:0] a);
        logic [20:0] x;
        for (int i = 0; i < 8; i++) begin
            x = a + 21'(i);
            exp_acc.push_back('{1'b0, x, 16'h0});
            exp_rd.push_back(x[15:0] ^ 16'hA5A5);
        end
    endtask

    task automatic drain(output bit to);
        int quiet;
        quiet = 0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!fetch_busy && !mem_req && !mem_ack) quiet++;
            else quiet = 0;
            if (quiet >= 6) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 21'h0 || mem_wdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_mem got=%b/%b/%h/%h exp=0/0/0/0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_rd got=%b/%h exp=0/0", rd_valid, rd_data);
        end
        checks++;
        if (fetch_busy !== 1'b0 || fetch_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch got=%b/%b exp=0/0", fetch_busy, fetch_overrun);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (wr_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b/%b exp=1/0", wr_ready, mem_req);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        acc_t e, o;
        logic [15:0] x;
        clear_logs();
        do_fetch(21'h00040);
        for (int i = 0; i < 500 && rd_log.size() < 3; i++) step();
        checks++;
        if (rd_log.size() != 3) begin
            failures++;
            $display("FAIL t1_beats got=%0d exp=3", rd_log.size());
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || rd_valid !== 1'b0 || wr_ready !== 1'b1 || fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL t1_in_reset got=%b/%b/%b/%b exp=0/0/1/0", mem_req, rd_valid, wr_ready, fetch_busy);
        end
        step();
        checks++;
        if (mem_req !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL t1_hold got=%b/%b exp=0/1", mem_req, wr_ready);
        end
        reset = 1'b0;
        step();
        clear_logs();
        exp_burst(21'h00080);
        do_fetch(21'h00080);
        drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL t1_drain got=timeout exp=idle");
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_log.size() == 0) begin
                failures++;
                $display("FAIL t1_acc got=none exp=%b/%h", e.we, e.addr);
            end else begin
                o = acc_log.pop_front();
                if (o.we !== e.we || o.addr !== e.addr) begin
                    failures++;
                    $display("FAIL t1_acc got=%b/%h exp=%b/%h", o.we, o.addr, e.we, e.addr);
                end
            end
        end
        while (exp_rd.size() > 0) begin
            x = exp_rd.pop_front();
            checks++;
            if (rd_log.size() == 0 || rd_log[0] !== x) begin
                failures++;
                $display("FAIL t1_rd got=%h exp=%h", rd_log.size() ? rd_log[0] : 16'hxxxx, x);
            end
            if (rd_log.size()) void'(rd_log.pop_front());
        end
        checks++;
        if (acc_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL t1_extra got=%0d/%0d exp=0/0", acc_log.size(), rd_log.size());
        end
    endtask

    task automatic test_burst();
        bit to;
        bit b7;
        acc_t e, o;
        logic [15:0] x;
        clear_logs();
        b7 = 1'b0;
        exp_burst(21'h00100);
        do_fetch(21'h00100);
        checks++;
        if (fetch_busy !== 1'b1) begin
            failures++;
            $display("FAIL t2_busy_set got=%b exp=1", fetch_busy);
        end
        for (int i = 0; i < 500 && rd_log.size() < 8; i++) begin
            step();
            if (rd_log.size() == 7) b7 = fetch_busy;
        end
        checks++;
        if (rd_log.size() != 8 || fetch_busy !== 1'b0 || b7 !== 1'b1) begin
            failures++;
            $display("FAIL t2_busy_drop got=%0d/%b/%b exp=8/0/1", rd_log.size(), fetch_busy, b7);
        end
        drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL t2_drain got=timeout exp=idle");
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_log.size() == 0) begin
                failures++;
                $display("FAIL t2_acc got=none exp=%b/%h", e.we, e.addr);
            end else begin
                o = acc_log.pop_front();
                if (o.we !== e.we || o.addr !== e.addr) begin
                    failures++;
                    $display("FAIL t2_acc got=%b/%h exp=%b/%h", o.we, o.addr, e.we, e.addr);
                end
            end
        end
        while (exp_rd.size() > 0) begin
            x = exp_rd.pop_front();
            checks++;
            if (rd_log.size() == 0 || rd_log[0] !== x) begin
                failures++;
                $display("FAIL t2_rd got=%h exp=%h", rd_log.size() ? rd_log[0] : 16'hxxxx, x);
            end
            if (rd_log.size()) void'(rd_log.pop_front());
        end
        checks++;
        if (acc_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL t2_extra got=%0d/%0d exp=0/0", acc_log.size(), rd_log.size());
        end
    endtask

    task automatic test_write_fifo();
        bit to;
        int stall_at;
        int rdy_log;
        int n;
        acc_t e, o;
        clear_logs();
        stall_at = -1;
        rdy_log = -1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 21'h00300 + 21'(i * 16);
            wr_data  = 16'h1000 + 16'(i * 3);
            exp_acc.push_back('{1'b1, wr_addr, wr_data});
            n = 0;
            while (!wr_ready && n < 100) begin
                if (stall_at < 0) stall_at = i;
                step();
                n++;
            end
            if (stall_at == i) rdy_log = acc_log.size();
            step();
        end
        wr_valid = 1'b0;
        checks++;
        if (stall_at != 4) begin
            failures++;
            $display("FAIL t3_stall_at got=%0d exp=4", stall_at);
        end
        checks++;
        if (rdy_log != 1) begin
            failures++;
            $display("FAIL t3_ready_after_ack got=%0d exp=1", rdy_log);
        end
        drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL t3_drain got=timeout exp=idle");
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_log.size() == 0) begin
                failures++;
                $display("FAIL t3_acc got=none exp=%b/%h/%h", e.we, e.addr, e.data);
            end else begin
                o = acc_log.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
                    failures++;
                    $display("FAIL t3_acc got=%b/%h/%h exp=%b/%h/%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
                end
            end
        end
        checks++;
        if (acc_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL t3_extra got=%0d/%0d exp=0/0", acc_log.size(), rd_log.size());
        end
    endtask

    task automatic test_fetch_during_write();
        bit to;
        acc_t e, o;
        logic [15:0] x;
        clear_logs();
        wr_valid = 1'b1;
        wr_addr  = 21'h00400;
        wr_data  = 16'hBEEF;
        exp_acc.push_back('{1'b1, wr_addr, wr_data});
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 50 && !mem_req; i++) step();
        step();
        fetch_req  = 1'b1;
        fetch_addr = 21'h00500;
        wr_valid   = 1'b1;
        wr_addr    = 21'h00410;
        wr_data    = 16'h1234;
        exp_burst(21'h00500);
        exp_acc.push_back('{1'b1, 21'h00410, 16'h1234});
        exp_acc.push_back('{1'b1, 21'h00420, 16'h5678});
        step();
        fetch_req = 1'b0;
        wr_addr   = 21'h00420;
        wr_data   = 16'h5678;
        step();
        wr_valid  = 1'b0;
        drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL t4_drain got=timeout exp=idle");
        end
        checks++;
        if (post_log.size() == 0 || post_log[0].req !== 1'b1 || post_log[0].we !== 1'b0 || post_log[0].addr !== 21'h00500) begin
            failures++;
            $display("FAIL t4_no_gap got=%b/%b/%h exp=1/0/00500",
                     post_log.size() ? post_log[0].req : 1'bx,
                     post_log.size() ? post_log[0].we : 1'bx,
                     post_log.size() ? post_log[0].addr : 21'hx);
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_log.size() == 0) begin
                failures++;
                $display("FAIL t4_acc got=none exp=%b/%h", e.we, e.addr);
            end else begin
                o = acc_log.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                    failures++;
                    $display("FAIL t4_acc got=%b/%h/%h exp=%b/%h/%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
                end
            end
        end
        while (exp_rd.size() > 0) begin
            x = exp_rd.pop_front();
            checks++;
            if (rd_log.size() == 0 || rd_log[0] !== x) begin
                failures++;
                $display("FAIL t4_rd got=%h exp=%h", rd_log.size() ? rd_log[0] : 16'hxxxx, x);
            end
            if (rd_log.size()) void'(rd_log.pop_front());
        end
        checks++;
        if (acc_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL t4_extra got=%0d/%0d exp=0/0", acc_log.size(), rd_log.size());
        end
    endtask

    task automatic test_wrap();
        bit to;
        acc_t e, o;
        logic [15:0] x;
        clear_logs();
        exp_burst(21'h1FFFFE);
        do_fetch(21'h1FFFFE);
        drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL t5_drain got=timeout exp=idle");
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_log.size() == 0) begin
                failures++;
                $display("FAIL t5_acc got=none exp=%b/%h", e.we, e.addr);
            end else begin
                o = acc_log.pop_front();
                if (o.we !== e.we || o.addr !== e.addr) begin
                    failures++;
                    $display("FAIL t5_acc got=%b/%h exp=%b/%h", o.we, o.addr, e.we, e.addr);
                end
            end
        end
        while (exp_rd.size() > 0) begin
            x = exp_rd.pop_front();
            checks++;
            if (rd_log.size() == 0 || rd_log[0] !== x) begin
                failures++;
                $display("FAIL t5_rd got=%h exp=%h", rd_log.size() ? rd_log[0] : 16'hxxxx, x);
            end
            if (rd_log.size()) void'(rd_log.pop_front());
        end
        checks++;
        if (acc_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL t5_extra got=%0d/%0d exp=0/0", acc_log.size(), rd_log.size());
        end
    endtask

    task automatic test_overrun();
        bit to;
        acc_t e, o;
        logic [15:0] x;
        clear_logs();
        exp_burst(21'h00600);
        do_fetch(21'h00600);
        for (int i = 0; i < 500 && rd_log.size() < 2; i++) step();
        checks++;
        if (fetch_overrun !== 1'b0 || fetch_busy !== 1'b1) begin
            failures++;
            $display("FAIL t6_before got=%b/%b exp=0/1", fetch_overrun, fetch_busy);
        end
        fetch_req  = 1'b1;
        fetch_addr = 21'h00700;
        step();
        fetch_req  = 1'b0;
        checks++;
        if (fetch_overrun !== 1'b1) begin
            failures++;
            $display("FAIL t6_set got=%b exp=1", fetch_overrun);
        end
        step();
        checks++;
        if (fetch_overrun !== 1'b1 || fetch_busy !== 1'b1) begin
            failures++;
            $display("FAIL t6_sticky got=%b/%b exp=1/1", fetch_overrun, fetch_busy);
        end
        fetch_req     = 1'b1;
        overrun_clear = 1'b1;
        step();
        fetch_req     = 1'b0;
        overrun_clear = 1'b0;
        checks++;
        if (fetch_overrun !== 1'b0) begin
            failures++;
            $display("FAIL t6_clear_wins got=%b exp=0", fetch_overrun);
        end
        drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL t6_drain got=timeout exp=idle");
        end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            checks++;
            if (acc_log.size() == 0) begin
                failures++;
                $display("FAIL t6_acc got=none exp=%b/%h", e.we, e.addr);
            end else begin
                o = acc_log.pop_front();
                if (o.we !== e.we || o.addr !== e.addr) begin
                    failures++;
                    $display("FAIL t6_acc got=%b/%h exp=%b/%h", o.we, o.addr, e.we, e.addr);
                end
            end
        end
        while (exp_rd.size() > 0) begin
            x = exp_rd.pop_front();
            checks++;
            if (rd_log.size() == 0 || rd_log[0] !== x) begin
                failures++;
                $display("FAIL t6_rd got=%h exp=%h", rd_log.size() ? rd_log[0] : 16'hxxxx, x);
            end
            if (rd_log.size()) void'(rd_log.pop_front());
        end
        checks++;
        if (acc_log.size() != 0 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL t6_extra got=%0d/%0d exp=0/0", acc_log.size(), rd_log.size());
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        fetch_req     = 1'b0;
        fetch_addr    = '0;
        overrun_clear = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        mcnt          = 0;
        test_reset();
        test_reset_mid_burst();
        test_burst();
        test_write_fifo();
        test_fetch_during_write();
        test_wrap();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
